// File: rtl/thermal_head_rx.sv
// Printhead serial receiver/checker: oversamples SCLK/DI/LAT/STB, captures lines,
// counts black dots, measures strobe width and flags protocol violations.
module thermal_head_rx #(
  parameter int DOTS    = 384,
  parameter int STB_MAX = 4000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SCLK,
  input  logic        DI,
  input  logic        LAT,
  input  logic        STB,
  input  logic        ERR_CLR,
  input  logic [8:0]  RD_ADDR,
  output logic        RD_DOT,
  output logic        LINE_VALID,
  output logic [8:0]  LINE_DOTS,
  output logic [12:0] STB_WIDTH,
  output logic [9:0]  BIT_COUNT,
  output logic [2:0]  ERR
);

  typedef enum logic [1:0] {IDLE, ARMED, STROBE} state_t;

  localparam logic [12:0] WSAT = 13'h1FFF;
  localparam logic [12:0] SMAX = 13'(STB_MAX);
  localparam logic [9:0]  BSAT = 10'h3FF;
  localparam logic [9:0]  NDOT = 10'(DOTS);
  localparam logic [8:0]  LAST = 9'(DOTS - 1);
  localparam logic [8:0]  AMAX = 9'(DOTS);

  // bit order in sync vectors: {STB, LAT, DI, SCLK}
  logic [3:0] s1, s2;
  logic [2:0] dly;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1  <= '0;
      s2  <= '0;
      dly <= '0;
    end else begin
      s1  <= {STB, LAT, DI, SCLK};
      s2  <= s1;
      dly <= {s2[3], s2[2], s2[0]};
    end
  end

  logic sclk_rise, di_s, lat_rise, stb_rise, stb_fall, stb_hi;

  assign sclk_rise = s2[0] & ~dly[0];
  assign di_s      = s2[1];
  assign lat_rise  = s2[2] & ~dly[1];
  assign stb_hi    = s2[3];
  assign stb_rise  = s2[3] & ~dly[2];
  assign stb_fall  = ~s2[3] & dly[2];

  state_t          state;
  logic [DOTS-1:0] shift_reg;
  logic [DOTS-1:0] latch_reg;
  logic [12:0]     wcnt;
  logic            counting;
  logic            scan_on;
  logic            scan_done;
  logic [8:0]      scan_idx;
  logic [8:0]      scan_cnt;
  logic            req;

  logic       in_strobe, scan_fin, req_now, fire;
  logic [2:0] err_set;
  logic [8:0] scan_sum;

  assign in_strobe = (state == STROBE);
  assign scan_sum  = scan_cnt + {8'b0, latch_reg[scan_idx]};
  // a restart in the same cycle discards the finishing scan
  assign scan_fin  = scan_on && (scan_idx == LAST) && !lat_rise;
  assign req_now   = in_strobe && stb_fall;
  assign fire      = (req || req_now) && (scan_done || scan_fin) && !lat_rise;

  assign err_set[0] = in_strobe && lat_rise;
  assign err_set[1] = in_strobe && counting && stb_hi && !stb_rise
                      && (wcnt == SMAX);
  assign err_set[2] = lat_rise && (BIT_COUNT < NDOT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      shift_reg  <= '0;
      latch_reg  <= '0;
      wcnt       <= '0;
      counting   <= 1'b0;
      scan_on    <= 1'b0;
      scan_done  <= 1'b0;
      scan_idx   <= '0;
      scan_cnt   <= '0;
      req        <= 1'b0;
      RD_DOT     <= 1'b0;
      LINE_VALID <= 1'b0;
      LINE_DOTS  <= '0;
      STB_WIDTH  <= '0;
      BIT_COUNT  <= '0;
      ERR        <= '0;
    end else begin
      if (sclk_rise)
        shift_reg <= {shift_reg[DOTS-2:0], di_s};

      if (lat_rise)
        BIT_COUNT <= '0;
      else if (sclk_rise && BIT_COUNT != BSAT)
        BIT_COUNT <= BIT_COUNT + 10'd1;

      if (lat_rise)
        latch_reg <= shift_reg;

      // width counter runs for every strobe; only STROBE requests a line pulse
      if (stb_rise) begin
        wcnt     <= 13'd1;
        counting <= 1'b1;
      end else if (counting) begin
        if (stb_hi && wcnt != WSAT)
          wcnt <= wcnt + 13'd1;
        if (stb_fall) begin
          STB_WIDTH <= wcnt;
          counting  <= 1'b0;
        end
      end

      if (lat_rise) begin
        scan_on   <= 1'b1;
        scan_done <= 1'b0;
        scan_idx  <= '0;
        scan_cnt  <= '0;
      end else if (scan_on) begin
        scan_cnt <= scan_sum;
        scan_idx <= scan_idx + 9'd1;
        if (scan_idx == LAST) begin
          scan_on   <= 1'b0;
          scan_done <= 1'b1;
          LINE_DOTS <= scan_sum;
        end
      end

      case (state)
        IDLE:    if (lat_rise) state <= ARMED;
        ARMED:   if (stb_rise) state <= STROBE;
        STROBE:  if (stb_fall) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (fire)
        req <= 1'b0;
      else if (req_now)
        req <= 1'b1;

      LINE_VALID <= fire;
      ERR        <= err_set | (ERR_CLR ? 3'b000 : ERR);
      RD_DOT     <= (RD_ADDR < AMAX) ? latch_reg[RD_ADDR] : 1'b0;
    end
  end

endmodule
